// File: rtl/qtestpd_st_to_ram_writer.sv
// qtestpd_st_to_ram_writer
//   Avalon-ST sink that captures one packet of 64-bit beats into the qtestpd
//   dual-port RAM through its s2 port. Software arms it with start/base_addr/
//   max_words and reads back word_count, done, overflow and proto_err.
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   start, base_addr,     arm pulse, first word address, word limit
//   max_words             (0 means full RAM depth)
//   st_*                  Avalon-ST sink (valid/ready/data/sop/eop/empty)
//   *2                    RAM s2 write port (address/byteenable/chipselect/
//                         write/writedata/clken)
//   busy, done,           status: armed/capturing, 1-cycle finish pulse,
//   word_count,           words written, sticky overflow and
//   overflow, proto_err   mid-packet sop flags
module qtestpd_st_to_ram_writer #(
    parameter int DATA_W  = 64,
    parameter int BE_W    = 8,
    parameter int ADDR_W  = 7,
    parameter int EMPTY_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W:0]    max_words,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [DATA_W-1:0]  st_data,
    input  logic               st_sop,
    input  logic               st_eop,
    input  logic [EMPTY_W-1:0] st_empty,
    output logic [ADDR_W-1:0]  address2,
    output logic [BE_W-1:0]    byteenable2,
    output logic               chipselect2,
    output logic               write2,
    output logic [DATA_W-1:0]  writedata2,
    output logic               clken2,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    word_count,
    output logic               overflow,
    output logic               proto_err
);

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAIN, FINISH} state_t;

    localparam logic [BE_W-1:0] BE_ALL    = '1;
    localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   limit_q;
    logic [ADDR_W:0]   wc_inc;
    logic              accept;
    logic              last_word;
    logic              wr_beat;
    logic              set_ovf;
    logic              set_perr;

    assign st_ready  = (state == ARM) || (state == CAPTURE) || (state == DRAIN);
    assign busy      = st_ready;
    assign done      = (state == FINISH);
    assign clken2    = 1'b1;
    assign accept    = st_valid && st_ready;
    assign wc_inc    = word_count + 1'b1;
    // The beat being written now is the one that fills the limit.
    assign last_word = (wc_inc == limit_q);

    always_comb begin
        state_nx = state;
        wr_beat  = 1'b0;
        set_ovf  = 1'b0;
        set_perr = 1'b0;
        case (state)
            IDLE: if (start) state_nx = ARM;
            ARM: begin
                // Non-sop beats before the packet are swallowed.
                if (accept && st_sop) begin
                    wr_beat = 1'b1;
                    if (st_eop) begin
                        state_nx = FINISH;
                    end else if (last_word) begin
                        state_nx = FINISH;
                        set_ovf  = 1'b1;
                    end else begin
                        state_nx = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (accept) begin
                    wr_beat  = 1'b1;
                    set_perr = st_sop;
                    if (st_eop) begin
                        state_nx = FINISH;
                    end else if (last_word) begin
                        state_nx = DRAIN;
                        set_ovf  = 1'b1;
                    end
                end
            end
            DRAIN:   if (accept && st_eop) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base_q      <= '0;
            limit_q     <= '0;
            word_count  <= '0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
            chipselect2 <= 1'b0;
            write2      <= 1'b0;
            address2    <= '0;
            byteenable2 <= '0;
            writedata2  <= '0;
        end else begin
            state       <= state_nx;
            chipselect2 <= wr_beat;
            write2      <= wr_beat;
            if (state == IDLE && start) begin
                base_q     <= base_addr;
                limit_q    <= (max_words == '0) ? FULL_DEPTH : max_words;
                word_count <= '0;
                overflow   <= 1'b0;
                proto_err  <= 1'b0;
            end else begin
                if (set_ovf)  overflow  <= 1'b1;
                if (set_perr) proto_err <= 1'b1;
            end
            if (wr_beat) begin
                // Address wraps modulo RAM depth through truncation.
                address2    <= base_q + word_count[ADDR_W-1:0];
                writedata2  <= st_data;
                byteenable2 <= st_eop ? (BE_ALL >> st_empty) : BE_ALL;
                word_count  <= wc_inc;
            end
        end
    end

endmodule

// File: tb/tb_qtestpd_st_to_ram_writer.sv
// Bench for qtestpd_st_to_ram_writer: directed packets plus randomized ones,
// checked against a packet-level model of the expected RAM writes.
module tb_qtestpd_st_to_ram_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [7:0]  max_words = '0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [63:0] st_data = '0;
    logic        st_sop = 1'b0;
    logic        st_eop = 1'b0;
    logic [2:0]  st_empty = '0;
    logic [6:0]  address2;
    logic [7:0]  byteenable2;
    logic        chipselect2;
    logic        write2;
    logic [63:0] writedata2;
    logic        clken2;
    logic        busy;
    logic        done;
    logic [7:0]  word_count;
    logic        overflow;
    logic        proto_err;

    qtestpd_st_to_ram_writer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .max_words(max_words), .st_valid(st_valid), .st_ready(st_ready),
        .st_data(st_data), .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
        .write2(write2), .writedata2(writedata2), .clken2(clken2), .busy(busy),
        .done(done), .word_count(word_count), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit sop; bit eop; bit [2:0] empty; bit [63:0] data; } beat_t;
    typedef struct { logic [6:0] a; logic [7:0] be; logic [63:0] d; } wr_t;

    int  tests = 0;
    int  fails = 0;
    wr_t got[$];
    int  done_total = 0;
    bit  last_done_wr = 0;

    task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        tests++;
        assert (got_v === exp_v) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // Write-port monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect2 !== write2) chk("cs_eq_write", chipselect2, write2);
            if (write2) got.push_back('{a: address2, be: byteenable2, d: writedata2});
            if (done) begin
                done_total++;
                last_done_wr = write2;
            end
        end
    end

    task automatic arm(input int base, input int maxw);
        base_addr = 7'(base);
        max_words = 8'(maxw);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input beat_t b);
        int  gap = $urandom_range(0, 2);
        int  guard = 0;
        bit  r;
        repeat (gap) begin st_valid = 1'b0; @(posedge clk); #1; end
        st_valid = 1'b1; st_sop = b.sop; st_eop = b.eop;
        st_empty = b.empty; st_data = b.data;
        do begin
            r = st_ready;
            @(posedge clk); #1;
            guard++;
        end while (!r && guard < 50);
        if (!r) chk("beat_accept_timeout", r, 1'b1);
        st_valid = 1'b0;
    endtask

    // Model: skip npre junk beats, packet of n beats starting at the first
    // sop; the first min(n,limit) beats land at consecutive wrapped addresses.
    task automatic run_pkt(input string tag, input int base, input int maxw, input int npre,
                           input int n, input int empty, input int mid_sop, input bit restart);
        beat_t bs[$];
        beat_t b;
        int    lim, nw, g0, d0;
        bit    ovf, perr;
        logic [7:0] be;
        for (int i = 0; i < npre; i++) begin
            b.sop = 0; b.eop = 1'($urandom); b.empty = 3'($urandom); b.data = {$urandom, $urandom};
            bs.push_back(b);
        end
        for (int k = 0; k < n; k++) begin
            b.sop = (k == 0) || (k == mid_sop); b.eop = (k == n - 1);
            b.empty = (k == n - 1) ? 3'(empty) : 3'($urandom);
            b.data = {$urandom, $urandom};
            bs.push_back(b);
        end
        lim  = (maxw == 0) ? 128 : maxw;
        nw   = (n < lim) ? n : lim;
        ovf  = (n > lim);
        perr = 0;
        for (int k = 1; k < nw; k++) if (bs[npre + k].sop) perr = 1;

        g0 = got.size(); d0 = done_total;
        arm(base, maxw);
        chk({tag, "_busy_armed"}, busy, 1'b1);
        if (restart && npre == 0) arm(base ^ 85, 3);
        for (int i = 0; i < bs.size(); i++) begin
            send(bs[i]);
            if (restart && i == npre - 1) arm(base ^ 85, 3);
        end
        repeat (3) @(posedge clk);
        #1;

        chk({tag, "_nwrites"}, got.size() - g0, nw);
        for (int k = 0; k < nw && g0 + k < got.size(); k++) begin
            be = (k == n - 1) ? (8'hFF >> empty) : 8'hFF;
            chk({tag, "_write"}, {got[g0+k].a, got[g0+k].be, got[g0+k].d},
                {7'((base + k) % 128), be, bs[npre + k].data});
        end
        chk({tag, "_done_pulses"}, done_total - d0, 1);
        chk({tag, "_done_with_write"}, last_done_wr, !ovf);
        chk({tag, "_word_count"}, word_count, nw);
        chk({tag, "_overflow"}, overflow, ovf);
        chk({tag, "_proto_err"}, proto_err, perr);
        chk({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_write2"}, write2, 1'b0);
        chk({tag, "_chipselect2"}, chipselect2, 1'b0);
        chk({tag, "_st_ready"}, st_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_outs"}, {address2, byteenable2, writedata2, word_count, overflow, proto_err}, '0);
        chk({tag, "_clken2"}, clken2, 1'b1);
    endtask

    initial begin
        beat_t b;
        int maxw, n;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_pkt("t1_base5",    5,   0, 0, 4, 0, -1, 0);
        run_pkt("t2_wrap",     126, 0, 0, 3, 0, -1, 0);
        run_pkt("t3_empty3",   20,  0, 0, 3, 3, -1, 0);
        run_pkt("t4_limit2",   40,  2, 0, 5, 0, -1, 0);
        run_pkt("t5_arm_junk", 60,  0, 2, 1, 5, -1, 1);
        run_pkt("t_midsop",    10,  0, 0, 4, 2, 2, 0);
        run_pkt("t_exact_lim", 100, 3, 1, 3, 7, -1, 0);

        for (int it = 0; it < 20; it++) begin
            maxw = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 8);
            n    = $urandom_range(1, 10);
            run_pkt("rand", $urandom_range(0, 127), maxw, $urandom_range(0, 2), n,
                    $urandom_range(0, 7),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : -1,
                    1'($urandom_range(0, 1)));
        end

        // Reset mid-packet with a beat still offered.
        arm(30, 0);
        b.sop = 1; b.eop = 0; b.empty = 0; b.data = 64'h1111;
        send(b);
        b.data = 64'h2222;
        send(b);
        chk("pre_reset_proto_err", proto_err, 1'b1);
        chk("pre_reset_write2", write2, 1'b1);
        st_valid = 1'b1; st_sop = 1'b0; st_data = 64'h3333;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("mid_reset");
        st_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
